// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath:
// instruction fields and memory/ALU status in, datapath and memory strobes out.
interface mips_mc_ctrl_if #(
  parameter int ALU_CTRL_W = 3
);
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic                  zero;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  iord;
  logic                  mem_read;
  logic                  mem_write;
  logic                  ir_write;
  logic [1:0]            reg_dst;
  logic [1:0]            mem_to_reg;
  logic                  reg_write;
  logic                  alu_src_a;
  logic [1:0]            alu_src_b;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic [1:0]            pc_src;
  logic                  fault;
  logic [1:0]            fault_code;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, fault, fault_code
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, fault, fault_code
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory watchdog and sticky fault trap.
// Define MIPS_MC_JAL_EN to add the JAL state (opcode 0x03); otherwise 0x03 traps.
module mips_mc_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALU_CTRL_W  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  mips_mc_ctrl_if.master bus
);
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
`ifdef MIPS_MC_JAL_EN
    S_JAL    = 4'd12,
`endif
    S_FAULT  = 4'd13
  } state_e;

  // {legal, alu op}
  function automatic logic [3:0] dec_funct(input logic [5:0] f);
    case (f)
      6'h20:   return {1'b1, ALU_ADD};
      6'h22:   return {1'b1, ALU_SUB};
      6'h24:   return {1'b1, ALU_AND};
      6'h25:   return {1'b1, ALU_OR};
      6'h2a:   return {1'b1, ALU_SLT};
      default: return 4'b0000;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [1:0]       fc_q, fc_d;
  logic [1:0]       trap;
  logic             wait_st;
  logic [3:0]       fdec;
  logic [2:0]       alu3;

  assign fdec = dec_funct(bus.funct);

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    fc_d    = fc_q;
    trap    = 2'b00;
    wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          6'h23, 6'h2b: state_d = S_MEMADR;
          6'h00:        state_d = S_EXEC;
          6'h04:        state_d = S_BRANCH;
          6'h08:        state_d = S_ADDIEX;
          6'h02:        state_d = S_JUMP;
`ifdef MIPS_MC_JAL_EN
          6'h03:        state_d = S_JAL;
`endif
          default:      trap = 2'b01;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == 6'h2b) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC:   if (fdec[3]) state_d = S_ALUWB; else trap = 2'b10;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
`ifdef MIPS_MC_JAL_EN
      S_JAL:    state_d = S_FETCH;
`endif
      default:  state_d = state_q;
    endcase
    // Watchdog: a ready arriving on the last allowed cycle still completes.
    if (wait_st && !bus.mem_ready && (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST))
      trap = 2'b11;
    if (trap != 2'b00) begin
      state_d = S_FAULT;
      fault_d = 1'b1;
      fc_d    = trap;
    end
    cnt_d = (wait_st && !bus.mem_ready && (state_d == state_q)) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      fc_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      fc_q    <= fc_d;
    end
  end

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_dst    = 2'b00;
    bus.mem_to_reg = 2'b00;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_src     = 2'b00;
    alu3           = 3'b000;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        alu3          = ALU_ADD;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        alu3          = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        alu3          = ALU_ADD;
      end
      S_MEMRD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b01;
      end
      S_MEMWR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        alu3          = fdec[2:0];
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 2'b01;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        alu3          = ALU_SUB;
        bus.pc_src    = 2'b01;
        bus.pc_write  = bus.zero;
      end
      S_ADDIWB: bus.reg_write = 1'b1;
      S_JUMP: begin
        bus.pc_src   = 2'b10;
        bus.pc_write = 1'b1;
      end
`ifdef MIPS_MC_JAL_EN
      // PC already holds PC+4, so it is the link value written to r31.
      S_JAL: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 2'b10;
        bus.mem_to_reg = 2'b10;
        bus.pc_src     = 2'b10;
        bus.pc_write   = 1'b1;
      end
`endif
      default: ;
    endcase
    bus.alu_ctrl = ALU_CTRL_W'(alu3);
    if (!rst_n) begin
      bus.pc_write  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.reg_write = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
    bus.fault      = fault_q;
    bus.fault_code = fc_q;
  end
endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle control unit for the next-generation MIPS core: a Moore-style FSM that sequences each instruction over several cycles through one shared memory port and one ALU, replacing the single-cycle combinational decode. It sits between the instruction register (opcode/funct fields) and the multicycle datapath. It waits on a memory-ready handshake, and it traps illegal opcodes, illegal funct codes and memory timeouts into a sticky fault state.

## Interface
- MEM_TIMEOUT, 16: maximum wait cycles per memory access before fault; 0 disables the watchdog.
- ALU_CTRL_W, 3: width of alu_ctrl; encodings ADD=010, SUB=110, AND=000, OR=001, SLT=111, zero-extended if wider.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; **synchronous, active-low**
- opcode  in  6  instr[31:26], valid from DECODE onward
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  PC update enable (includes branch-taken)
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_dst  out  2  00=rt, 01=rd, 10=r31
- mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=sext imm, 11=sext imm<<2
- alu_ctrl  out  ALU_CTRL_W  ALU operation
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- fault  out  1  sticky fault flag
- fault_code  out  2  01=illegal opcode, 10=illegal funct, 11=memory timeout

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, JAL (macro only), FAULT.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00.
  - While mem_ready=0: hold in FETCH with no writes.
  - When mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_ctrl=ADD (precompute branch target).
  - Dispatch on opcode: 0x23/0x2b→MEMADR; 0x00→EXEC; 0x04→BRANCH; 0x08→ADDIEX; 0x02→JUMP; 0x03→JAL (macro only); anything else→FAULT with code 01.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD; go to MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_read=1, iord=1; wait for mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01; go to FETCH.
- MEMWR: mem_write=1, iord=1; wait for mem_ready, then go to FETCH.
- EXEC:
  - alu_src_a=1, alu_src_b=00; alu_ctrl decoded from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2a SLT.
  - Legal funct → ALUWB. Any other funct → FAULT with code 10.
- ALUWB: reg_write=1, reg_dst=01, mem_to_reg=00; go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_write=zero; go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ADD; go to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=00, mem_to_reg=00; go to FETCH.
- JUMP: pc_src=10, pc_write=1; go to FETCH.
- FAULT:
  - Absorbing until reset.
  - All write/request outputs are 0.
  - fault=1; fault_code holds the first cause.
- Memory watchdog:
  - A wait counter increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - It clears on mem_ready=1 and on any state change.
  - If it reaches MEM_TIMEOUT with mem_ready still 0, the FSM goes to FAULT with code 11.
  - A mem_ready=1 arriving in that same cycle wins: no fault.
- Default output values in any state where not listed: all 0.

## Timing
- State register and wait counter update on the rising clk edge.
- Outputs are decoded from the registered state. Exceptions: ir_write and pc_write in FETCH are additionally gated by mem_ready, and pc_write in BRANCH is gated by zero.
- Cycles per instruction with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, jal 3. Each wait cycle adds 1.
- Reset:
  - rst_n=0 sampled at an edge gives state=FETCH, counter=0, fault=0, fault_code=00.
  - While rst_n=0, all write and request outputs (pc_write, ir_write, reg_write, mem_read, mem_write) are forced to 0 combinationally.
  - Reset in the middle of a wait or in FAULT restarts at FETCH on the next cycle.
- The first cycle after reset release is FETCH with mem_read=1.

## Configuration
- MIPS_MC_JAL_EN defined:
  - Opcode 0x03 goes DECODE→JAL.
  - JAL asserts reg_write=1, reg_dst=10, mem_to_reg=10, pc_src=10, pc_write=1, then goes to FETCH. PC still holds PC+4 at this point.
- MIPS_MC_JAL_EN undefined: no JAL state; opcode 0x03 → FAULT with code 01.

## Test plan
- Reset, then lw (opcode 0x23) with mem_ready=1 → state trace FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; reg_write=1 only in MEMWB with mem_to_reg=01.
- R-type funct 0x22 → alu_ctrl=110 in EXEC, reg_dst=01 in ALUWB. Repeat with funct 0x3f → FAULT, fault_code=10, sticky for 20 cycles until rst_n=0.
- beq: zero=1 → pc_write=1, pc_src=01 in BRANCH. zero=0 → pc_write=0 in BRANCH. Both take 3 cycles.
- sw with mem_ready held 0 for 5 cycles → stays in MEMWR with mem_write=1 for 6 cycles, no fault. Hold 0 for 16 cycles with MEM_TIMEOUT=16 → FAULT, code 11.
- Opcode 0x03:
  - With MIPS_MC_JAL_EN → reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, 3 cycles.
  - Without → FAULT, code 01.
- rst_n=0 asserted during a FETCH wait → next cycle FETCH, counter 0, no writes asserted in the reset cycle.
